// File: rtl/sm_trace_buffer.sv
// Retired-instruction trace capture for schoolMIPS: {pc, instr, stamp} into a
// circular buffer with fill-once, PC-trigger and free-running capture modes.
module sm_trace_buffer #(
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = 4,
    parameter int STAMP_W        = 16,
    parameter int TIMEOUT_CYCLES = 120
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic               stop,
    input  logic               valid,
    input  logic [31:0]        pc,
    input  logic [31:0]        instr,
    input  logic [1:0]         trigMode,
    input  logic [31:0]        trigPc,
    input  logic [ADDR_W-1:0]  postCount,
    input  logic [ADDR_W-1:0]  rdIdx,
    output logic [31:0]        rdPc,
    output logic [31:0]        rdInstr,
    output logic [STAMP_W-1:0] rdStamp,
    output logic [1:0]         state,
    output logic [ADDR_W:0]    count,
    output logic               triggered,
    output logic [ADDR_W-1:0]  trigIdx,
    output logic [STAMP_W-1:0] cycleCnt,
    output logic               timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]    FULL    = (ADDR_W+1)'(DEPTH);
    localparam logic [STAMP_W-1:0] TO_VAL  = STAMP_W'(TIMEOUT_CYCLES);

    state_t              stateQ, stateNext;
    logic [ADDR_W-1:0]   wrPtr;
    logic [ADDR_W-1:0]   trigPtr;
    logic [ADDR_W-1:0]   remain;
    logic [1:0]          modeL;
    logic [31:0]         trigPcL;
    logic [ADDR_W-1:0]   postCountL;

    logic                active;
    logic                doWrite;
    logic                setTrig;
    logic [ADDR_W-1:0]   oldest;
    logic [ADDR_W-1:0]   rdAddr;
    logic [STAMP_W-1:0]  cycleInc;

    logic [31:0]         memPc    [DEPTH];
    logic [31:0]         memInstr [DEPTH];
    logic [STAMP_W-1:0]  memStamp [DEPTH];

    assign state    = stateQ;
    assign active   = (stateQ == ARMED) || (stateQ == POST);
    assign doWrite  = active && valid && !arm;
    assign oldest   = (count == FULL) ? wrPtr : '0;
    assign trigIdx  = trigPtr - oldest;
    assign rdAddr   = oldest + rdIdx;
    assign cycleInc = (cycleCnt == '1) ? cycleCnt : cycleCnt + 1'b1;

    always_comb begin
        stateNext = stateQ;
        setTrig   = 1'b0;
        case (stateQ)
            ARMED: begin
                if (modeL == 2'd0 && doWrite && count == FULL - 1'b1) begin
                    stateNext = DONE;
                end else if (modeL == 2'd1 && doWrite && pc == trigPcL) begin
                    setTrig   = 1'b1;
                    stateNext = (postCountL == '0) ? DONE : POST;
                end
            end
            POST: begin
                if (doWrite && remain == ADDR_W'(1)) stateNext = DONE;
            end
            default: ;
        endcase
        // stop still lets a same-cycle valid land (doWrite is independent of stop)
        if (active && stop) stateNext = DONE;
        if (arm) stateNext = ARMED;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ     <= IDLE;
            wrPtr      <= '0;
            count      <= '0;
            triggered  <= 1'b0;
            trigPtr    <= '0;
            remain     <= '0;
            cycleCnt   <= '0;
            timeout    <= 1'b0;
            modeL      <= '0;
            trigPcL    <= '0;
            postCountL <= '0;
        end else if (arm) begin
            stateQ     <= stateNext;
            wrPtr      <= '0;
            count      <= '0;
            triggered  <= 1'b0;
            trigPtr    <= '0;
            remain     <= '0;
            cycleCnt   <= '0;
            timeout    <= 1'b0;
            modeL      <= trigMode;
            trigPcL    <= trigPc;
            postCountL <= postCount;
        end else begin
            stateQ <= stateNext;
            if (doWrite) begin
                wrPtr <= wrPtr + 1'b1;
                if (count != FULL) count <= count + 1'b1;
            end
            if (setTrig) begin
                triggered <= 1'b1;
                trigPtr   <= wrPtr;
                remain    <= postCountL;
            end else if (stateQ == POST && doWrite) begin
                remain <= remain - 1'b1;
            end
            if (active) begin
                cycleCnt <= cycleInc;
                if (cycleInc == TO_VAL && cycleCnt != cycleInc) timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doWrite && !rst) begin
            memPc[wrPtr]    <= pc;
            memInstr[wrPtr] <= instr;
            memStamp[wrPtr] <= cycleCnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || ({1'b0, rdIdx} >= count)) begin
            rdPc    <= '0;
            rdInstr <= '0;
            rdStamp <= '0;
        end else begin
            rdPc    <= memPc[rdAddr];
            rdInstr <= memInstr[rdAddr];
            rdStamp <= memStamp[rdAddr];
        end
    end

endmodule

// File: tb/tb_sm_trace_buffer.sv
// Directed scoreboard bench for sm_trace_buffer: stimulus queues expected
// observations, a negedge monitor pops and compares them.
module tb_sm_trace_buffer;

    logic        clk = 1'b0;
    logic        rst, arm, stop, valid;
    logic [31:0] pc, instr, trigPc;
    logic [1:0]  trigMode;
    logic [3:0]  postCount, rdIdx;
    logic [31:0] rdPc, rdInstr;
    logic [15:0] rdStamp, cycleCnt;
    logic [1:0]  state;
    logic [4:0]  count;
    logic        triggered, timeout;
    logic [3:0]  trigIdx;

    sm_trace_buffer #(.DEPTH(16), .ADDR_W(4), .STAMP_W(16), .TIMEOUT_CYCLES(120)) dut (
        .clk(clk), .rst(rst), .arm(arm), .stop(stop), .valid(valid),
        .pc(pc), .instr(instr), .trigMode(trigMode), .trigPc(trigPc),
        .postCount(postCount), .rdIdx(rdIdx), .rdPc(rdPc), .rdInstr(rdInstr),
        .rdStamp(rdStamp), .state(state), .count(count), .triggered(triggered),
        .trigIdx(trigIdx), .cycleCnt(cycleCnt), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef enum int {S_STATE, S_COUNT, S_TRIG, S_TIDX, S_CYC, S_TO, S_PC, S_INSTR, S_STAMP} sel_t;
    typedef struct {
        string       name;
        sel_t        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   nVec = 0;
    int   nMis = 0;

    function automatic logic [31:0] actual(sel_t s);
        case (s)
            S_STATE: return {30'd0, state};
            S_COUNT: return {27'd0, count};
            S_TRIG:  return {31'd0, triggered};
            S_TIDX:  return {28'd0, trigIdx};
            S_CYC:   return {16'd0, cycleCnt};
            S_TO:    return {31'd0, timeout};
            S_PC:    return rdPc;
            S_INSTR: return rdInstr;
            default: return {16'd0, rdStamp};
        endcase
    endfunction

    function automatic void chk(string n, sel_t s, logic [31:0] v);
        exp_t e;
        e.name = n;
        e.sel  = s;
        e.exp  = v;
        sbq.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic [31:0] a;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            a = actual(e.sel);
            nVec++;
            if (a !== e.exp) begin
                nMis++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, a, e.exp);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic doArm(input logic [1:0] m, input logic [31:0] tp, input logic [3:0] pcnt);
        trigMode = m; trigPc = tp; postCount = pcnt;
        arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    task automatic push(input logic [31:0] p, input logic [31:0] i);
        valid = 1'b1; pc = p; instr = i;
        cyc();
        valid = 1'b0;
    endtask

    task automatic readAt(input logic [3:0] idx);
        rdIdx = idx;
        cyc();
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; stop = 1'b0; valid = 1'b0;
        pc = '0; instr = '0; trigPc = '0; trigMode = '0; postCount = '0; rdIdx = '0;
        cyc(); cyc();
        chk("rst_state", S_STATE, 0); chk("rst_count", S_COUNT, 0);
        chk("rst_trig", S_TRIG, 0);   chk("rst_tidx", S_TIDX, 0);
        chk("rst_cyc", S_CYC, 0);     chk("rst_to", S_TO, 0);
        chk("rst_rdpc", S_PC, 0);
        rst = 1'b0;
        cyc();

        // Mode 0: fill-once, DONE on the 16th write
        doArm(2'd0, 32'h0, 4'd0);
        chk("m0_armed", S_STATE, 1);
        for (int n = 0; n < 20; n++) begin
            push(32'(4 * n), 32'h1000 + 32'(n));
            if (n == 14) begin chk("m0_st15", S_STATE, 1); chk("m0_cnt15", S_COUNT, 15); end
            if (n == 15) begin chk("m0_done", S_STATE, 3); chk("m0_cnt16", S_COUNT, 16); end
        end
        chk("m0_cnt_after", S_COUNT, 16);
        chk("m0_cyc_frozen", S_CYC, 16);
        readAt(4'd0);
        chk("m0_rd0_pc", S_PC, 32'h0); chk("m0_rd0_instr", S_INSTR, 32'h1000);
        chk("m0_rd0_stamp", S_STAMP, 0);
        readAt(4'd15);
        chk("m0_rd15_pc", S_PC, 32'h3C); chk("m0_rd15_stamp", S_STAMP, 15);

        // Mode 1: trigPc input changed after arm must be ignored
        doArm(2'd1, 32'h40, 4'd3);
        trigPc = 32'h0; postCount = 4'd0;
        for (int n = 0; n < 22; n++) begin
            push(32'(4 * n), 32'h2000 + 32'(n));
            if (n == 0)  chk("m1_no_early_trig", S_TRIG, 0);
            if (n == 16) begin chk("m1_trig", S_TRIG, 1); chk("m1_post", S_STATE, 2); end
            if (n == 18) chk("m1_still_post", S_STATE, 2);
            if (n == 19) begin chk("m1_done", S_STATE, 3); chk("m1_cnt", S_COUNT, 16); end
        end
        chk("m1_tidx", S_TIDX, 12);
        readAt(4'd0);  chk("m1_rd0", S_PC, 32'h10);
        readAt(4'd15); chk("m1_rd15", S_PC, 32'h4C);
        readAt(4'd12); chk("m1_rd12", S_PC, 32'h40);

        // Mode 2: stop with valid on the same cycle
        doArm(2'd2, 32'h0, 4'd0);
        for (int n = 0; n < 5; n++) push(32'(4 * n), 32'h3000 + 32'(n));
        stop = 1'b1;
        push(32'h14, 32'h3005);
        chk("m2_done", S_STATE, 3); chk("m2_cnt", S_COUNT, 6);
        push(32'h18, 32'h3006);
        stop = 1'b0;
        chk("m2_cnt_hold", S_COUNT, 6); chk("m2_state_hold", S_STATE, 3);
        readAt(4'd5); chk("m2_rd5", S_PC, 32'h14);
        readAt(4'd6); chk("m2_rd6_zero", S_PC, 32'h0);

        // Arm with valid while in POST
        doArm(2'd1, 32'h8, 4'd5);
        push(32'h0, 32'h1); push(32'h4, 32'h2); push(32'h8, 32'h3);
        chk("ap_post", S_STATE, 2);
        push(32'hC, 32'h4);
        valid = 1'b1; pc = 32'h100; instr = 32'h5;
        arm = 1'b1; trigMode = 2'd2;
        rdIdx = 4'd0;
        cyc();
        arm = 1'b0; valid = 1'b0;
        chk("ap_state", S_STATE, 1); chk("ap_cnt", S_COUNT, 0); chk("ap_trig", S_TRIG, 0);
        cyc(); chk("ap_rd_empty", S_PC, 0);
        push(32'h200, 32'h6);
        readAt(4'd0); chk("ap_rd0", S_PC, 32'h200);

        // Timeout
        doArm(2'd2, 32'h0, 4'd0);
        chk("to_cyc0", S_CYC, 0);
        repeat (119) cyc();
        chk("to_pre", S_TO, 0); chk("to_cyc119", S_CYC, 119);
        cyc();
        chk("to_set", S_TO, 1); chk("to_cyc120", S_CYC, 120);
        repeat (5) cyc();
        chk("to_sticky", S_TO, 1); chk("to_cyc125", S_CYC, 125);
        doArm(2'd2, 32'h0, 4'd0);
        chk("to_clr", S_TO, 0); chk("to_cyc_clr", S_CYC, 0);

        // Reset mid-capture
        doArm(2'd2, 32'h0, 4'd0);
        for (int n = 0; n < 7; n++) push(32'h300 + 32'(4 * n), 32'(n));
        chk("rs_cnt7", S_COUNT, 7);
        readAt(4'd3); chk("rs_rd3", S_PC, 32'h30C);
        rst = 1'b1; valid = 1'b1; pc = 32'h999;
        cyc();
        rst = 1'b0; valid = 1'b0;
        chk("rs_state", S_STATE, 0); chk("rs_cnt", S_COUNT, 0); chk("rs_rdpc", S_PC, 0);
        doArm(2'd2, 32'h0, 4'd0);
        push(32'h500, 32'h0); push(32'h504, 32'h0);
        readAt(4'd2); chk("rs_rd2_zero", S_PC, 0);
        readAt(4'd1); chk("rs_rd1", S_PC, 32'h504);

        begin
            int waitCnt = 0;
            while (sbq.size() > 0 && waitCnt < 10) begin
                cyc();
                waitCnt++;
            end
            if (sbq.size() > 0) begin
                $display("FAIL drain: got %0d pending expected 0", sbq.size());
                nMis++;
            end
        end
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/sm_trace_buffer.md
Name: sm_trace_buffer

Overview:
- Synthesizable retired-instruction trace capture for the schoolMIPS core.
- Records {pc, instr, cycle stamp} per retired instruction into a DEPTH-entry circular buffer.
- Supports fill-once, PC-match trigger with post-trigger count, and free-running capture modes.
- Sits beside sm_cpu and is fed from the writeback stage. Readout goes through an indexed port, giving the in-silicon equivalent of the bench cycle trace, including its cycle timeout.

Parameters:
DEPTH, 16, trace entries; power of two, >=2
ADDR_W, 4, log2(DEPTH)
STAMP_W, 16, cycle-stamp/counter width
TIMEOUT_CYCLES, 120, cycle count at which timeout sets

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
arm  in  1  start/restart capture (single-cycle pulse)
stop  in  1  force capture end
valid  in  1  instruction retired this cycle
pc  in  32  retired instruction PC
instr  in  32  retired instruction word
trigMode  in  2  0=fill-once, 1=PC trigger, 2=free-running, 3=reserved (treated as 2)
trigPc  in  32  trigger PC (mode 1)
postCount  in  ADDR_W  entries captured after the trigger entry (mode 1)
rdIdx  in  ADDR_W  read index; 0 = oldest entry
rdPc  out  32  pc of entry rdIdx
rdInstr  out  32  instr of entry rdIdx
rdStamp  out  STAMP_W  stamp of entry rdIdx
state  out  2  0=IDLE 1=ARMED 2=POST 3=DONE
count  out  ADDR_W+1  valid entries, 0..DEPTH
triggered  out  1  trigger seen since arm
trigIdx  out  ADDR_W  relative index of trigger entry (valid when triggered)
cycleCnt  out  STAMP_W  cycles since arm
timeout  out  1  sticky; cycleCnt reached TIMEOUT_CYCLES

Behaviour:
- Reset: state=IDLE; wrPtr, count, triggered, trigIdx, cycleCnt, timeout all 0; rdPc, rdInstr, rdStamp all 0. Memory contents are not reset.
- arm (any state, highest priority over stop/valid/rst-free logic):
  - next state=ARMED; wrPtr, count, triggered, cycleCnt, timeout cleared.
  - trigMode, trigPc and postCount latched; later changes are ignored until the next arm.
  - A valid on the arm cycle is NOT captured.
- Capture (ARMED/POST, valid=1, no arm):
  - mem[wrPtr] <= {pc, instr, cycleCnt}; wrPtr <= wrPtr+1 mod DEPTH; count <= min(count+1, DEPTH).
- cycleCnt: +1 every cycle in ARMED/POST, saturates at all-ones, frozen in IDLE/DONE. First cycle after the arm edge has stamp 0.
- timeout: set on the edge where cycleCnt becomes TIMEOUT_CYCLES (ARMED/POST only). Sticky until arm/rst. Does not stop capture.
- Mode 0: the write that makes count==DEPTH also moves state to DONE on the same edge.
- Mode 1, trigger:
  - In ARMED, valid & pc==trigPc writes the entry and sets triggered=1. trigPtr records the physical location of that entry.
  - If postCount==0, go to DONE; else go to POST with remain=postCount.
  - In POST, each write decrements remain; the write taking remain to 0 moves to DONE.
  - postCount<=DEPTH-1, so the trigger entry is never overwritten. Buffer wraps freely in ARMED.
- Mode 2: wraps indefinitely; only stop ends capture.
- stop in ARMED/POST: go to DONE. A valid on the same cycle is captured first. stop in IDLE/DONE is ignored.
- Pointer arithmetic:
  - oldest = (count==DEPTH) ? wrPtr : 0.
  - trigIdx = (trigPtr - oldest) mod DEPTH.
- Readout: rdPc/rdInstr/rdStamp are registered with 1-cycle latency from rdIdx, reading mem[(oldest+rdIdx) mod DEPTH]. rdIdx>=count returns zeros. Reads are legal in any state, including during capture.
- rst mid-capture: returns to IDLE with cleared counters; no further writes.

Test Plan:
- Mode 0, DEPTH=16: arm, 20 valids with pc=4n -> DONE on 16th write; count=16; extra valids ignored; rdIdx 0 -> pc 0x0, rdIdx 15 -> pc 0x3C, rdStamp(0)=0 for back-to-back valids starting the cycle after arm.
- Mode 1, trigPc=0x40, postCount=3, valids pc=4n -> triggered at pc 0x40; DONE after pc 0x4C write; count=16; rdIdx 0 -> 0x10; trigIdx=12; rdIdx 15 -> 0x4C.
- Mode 2: 5 valids, then stop with valid (pc=0x14) same cycle -> DONE, count=6, rdIdx 5 -> 0x14; further valid/stop ignored.
- In POST, arm with valid the same cycle -> state=ARMED, count=0, triggered=0, that entry not present.
- Arm, no valids, TIMEOUT_CYCLES=120 -> timeout rises exactly 120 clocks after the arm edge, stays high; cycleCnt keeps counting; next arm clears it.
- rst asserted mid-ARMED with count=7 -> state=IDLE, count=0, rd outputs 0 the next cycle; rdIdx>=count returns zeros after re-arm.
